// File: rtl/dmem_be_pkg.sv
// Shared constants for the byte-enabled data memory: read-during-write modes
// and the clear/run state encodings.
package dmem_be_pkg;

  localparam int unsigned DMEM_RDW_READ_FIRST  = 0;
  localparam int unsigned DMEM_RDW_WRITE_FIRST = 1;

  typedef enum logic {
    DMEM_ST_CLEAR = 1'b0,
    DMEM_ST_RUN   = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/dmem_be_bank.sv
// One byte lane of the data memory: DEPTH x 8 storage with its own write
// enable and an asynchronous read of the addressed byte.
module dmem_be_bank #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata_c
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata_c = mem[idx];

endmodule

// File: rtl/dmem_be.sv
// Single-port data RAM with byte enables, selectable read-during-write result,
// read hold, out-of-range detection and an optional post-reset clear sweep.
module dmem_be
  import dmem_be_pkg::*;
#(
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       DEPTH          = 2048,
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       RDW_MODE       = DMEM_RDW_READ_FIRST,
  parameter int unsigned       CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLR_VAL        = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  re,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  output logic                  addr_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned CNT_W = IDX_W + 1;

  dmem_state_e       state;
  logic [CNT_W-1:0]  clr_cnt;
  logic [CNT_W-1:0]  clr_cnt_nxt;
  logic [IDX_W-1:0]  bank_idx;
  logic [DATA_W-1:0] bank_wdata;
  logic [NB-1:0]     bank_we;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] new_word;
  logic              in_range;
  logic              run;

  // Any address bit above the index field marks the access out of range.
  if (ADDR_W > IDX_W) begin : g_range
    assign in_range = ~|addr[ADDR_W-1:IDX_W];
  end else begin : g_norange
    assign in_range = 1'b1;
  end

  assign run         = (state == DMEM_ST_RUN);
  assign clr_cnt_nxt = clr_cnt + CNT_W'(1);

  // Byte-lane steering: the clear sweep owns the array until RUN.
  always_comb begin
    bank_idx   = clr_cnt[IDX_W-1:0];
    bank_wdata = CLR_VAL;
    bank_we    = '0;
    new_word   = old_word;
    for (int i = 0; i < int'(NB); i++) begin
      if (be[i]) new_word[8*i +: 8] = wdata[8*i +: 8];
    end
    if (run) begin
      bank_idx   = addr[IDX_W-1:0];
      bank_wdata = wdata;
      bank_we    = (we && in_range && !reset) ? be : '0;
    end else if (!reset) begin
      bank_we = '1;
    end
  end

  for (genvar i = 0; i < int'(NB); i++) begin : g_bank
    dmem_be_bank #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
    ) u_bank (
      .clk     (clk),
      .we      (bank_we[i]),
      .idx     (bank_idx),
      .wdata   (bank_wdata[8*i +: 8]),
      .rdata_c (old_word[8*i +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? DMEM_ST_CLEAR : DMEM_ST_RUN;
      clr_cnt  <= '0;
      ready    <= (CLEAR_ON_RESET == 0);
      rdata    <= '0;
      addr_err <= 1'b0;
    end else begin
      case (state)
        DMEM_ST_CLEAR: begin
          rdata    <= '0;
          addr_err <= 1'b0;
          clr_cnt  <= clr_cnt_nxt;
          if (clr_cnt_nxt == CNT_W'(DEPTH)) begin
            state <= DMEM_ST_RUN;
            ready <= 1'b1;
          end
        end
        DMEM_ST_RUN: begin
          ready    <= 1'b1;
          addr_err <= (we || re) && !in_range;
          if (re && in_range) begin
            rdata <= ((RDW_MODE == DMEM_RDW_WRITE_FIRST) && we) ? new_word : old_word;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_be.sv
// Bench for dmem_be: three configurations driven in lockstep and checked
// against a word-level memory model every cycle, plus literal expectations.
module tb_dmem_be;

  localparam logic [31:0] CLR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [3:0]  be;
  logic [31:0] rd  [3];
  logic        rdy [3];
  logic        err [3];

  int n_err = 0;
  int n_chk = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  dmem_be #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .RDW_MODE(0), .CLEAR_ON_RESET(1),
            .CLR_VAL(CLR)) u_rf (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .be(be), .re(re),
    .rdata(rd[0]), .ready(rdy[0]), .addr_err(err[0]));

  dmem_be #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .RDW_MODE(1), .CLEAR_ON_RESET(1),
            .CLR_VAL(CLR)) u_wf (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .be(be), .re(re),
    .rdata(rd[1]), .ready(rdy[1]), .addr_err(err[1]));

  dmem_be #(.DATA_W(32), .DEPTH(2048), .ADDR_W(32), .RDW_MODE(0), .CLEAR_ON_RESET(0),
            .CLR_VAL(CLR)) u_big (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .be(be), .re(re),
    .rdata(rd[2]), .ready(rdy[2]), .addr_err(err[2]));

  function automatic int unsigned m_depth(input int k);
    return (k == 2) ? 2048 : 16;
  endfunction

  function automatic bit m_wfirst(input int k);
    return k == 1;
  endfunction

  function automatic bit m_clr_on(input int k);
    return k != 2;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // Word-level model: a plain array per configuration, filled wholesale at the
  // end of the clear window, with a known-flag for never-written words.
  logic [31:0] mmem [3][2048];
  bit          mval [3][2048];
  logic [31:0] e_rd [3];
  bit          e_rd_known [3];
  bit          e_err [3];
  bit          clearing [3];
  int          clr_n [3];

  task automatic model_step(input int k);
    logic [31:0] oldw;
    logic [31:0] neww;
    int unsigned a;
    if (reset) begin
      e_rd[k] = '0;
      e_rd_known[k] = 1'b1;
      e_err[k] = 1'b0;
      clearing[k] = m_clr_on(k);
      clr_n[k] = 0;
    end else if (clearing[k]) begin
      clr_n[k]++;
      if (clr_n[k] == int'(m_depth(k))) begin
        for (int j = 0; j < int'(m_depth(k)); j++) begin
          mmem[k][j] = CLR;
          mval[k][j] = 1'b1;
        end
        clearing[k] = 1'b0;
      end
    end else begin
      e_err[k] = (we || re) && (addr >= m_depth(k));
      if (addr < m_depth(k)) begin
        a = addr;
        oldw = mmem[k][a];
        neww = oldw;
        for (int b = 0; b < 4; b++) if (be[b]) neww[8*b +: 8] = wdata[8*b +: 8];
        if (re) begin
          if (m_wfirst(k) && we) begin
            e_rd[k] = neww;
            e_rd_known[k] = mval[k][a] || (be == 4'hF);
          end else begin
            e_rd[k] = oldw;
            e_rd_known[k] = mval[k][a];
          end
        end
        if (we) begin
          mmem[k][a] = neww;
          if (be == 4'hF) mval[k][a] = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_ready[%0d]", k), 32'(rdy[k]), 32'(!clearing[k]));
        chk($sformatf("model_addr_err[%0d]", k), 32'(err[k]), 32'(e_err[k]));
        if (e_rd_known[k]) chk($sformatf("model_rdata[%0d]", k), rd[k], e_rd[k]);
      end
    end
  end

  task automatic drive(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    we = w; re = r; addr = a; wdata = d; be = b;
    @(negedge clk);
  endtask

  // Counts ready across a clear window that starts at the current negedge.
  task automatic check_clear_window(input string tag);
    chk({tag, "_ready_start"}, 32'(rdy[0]), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("%s_ready_c%0d", tag, k), 32'(rdy[0]), 32'(k == 16));
    end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; be = '0;
    repeat (2) @(negedge clk);
    started = 1'b1;

    // Clear window with accesses attempted throughout.
    reset = 1'b0; we = 1'b1; re = 1'b1; addr = 32'd7; wdata = 32'h55; be = 4'hF;
    check_clear_window("clr");
    chk("big_ready_noclr", 32'(rdy[2]), 32'd1);

    drive(1'b0, 1'b1, 32'd0, '0, 4'h0);  chk("clr_rd0",  rd[0], CLR);
    drive(1'b0, 1'b1, 32'd7, '0, 4'h0);  chk("clr_rd7",  rd[0], CLR);
    chk("big_rd7", rd[2], 32'h55);
    drive(1'b0, 1'b1, 32'd15, '0, 4'h0); chk("clr_rd15", rd[0], CLR);

    // Byte-enable merge.
    drive(1'b1, 1'b0, 32'd5, 32'h11223344, 4'hF);
    drive(1'b1, 1'b0, 32'd5, 32'hAABBCCDD, 4'b0101);
    drive(1'b0, 1'b1, 32'd5, '0, 4'h0);
    chk("be_merge_rf", rd[0], 32'h11BB33DD);
    chk("be_merge_wf", rd[1], 32'h11BB33DD);

    // Read-during-write, same word.
    drive(1'b1, 1'b0, 32'd3, 32'h0, 4'hF);
    drive(1'b1, 1'b1, 32'd3, 32'hFFFF0000, 4'hC);
    chk("rdw_read_first",  rd[0], 32'h00000000);
    chk("rdw_write_first", rd[1], 32'hFFFF0000);

    // Out of range write plus read.
    drive(1'b1, 1'b0, 32'd0, 32'hCAFEF00D, 4'hF);
    drive(1'b0, 1'b1, 32'd0, '0, 4'h0);
    drive(1'b1, 1'b1, 32'h800, 32'h5A5A5A5A, 4'hF);
    chk("oor_err_big",  32'(err[2]), 32'd1);
    chk("oor_hold_big", rd[2], 32'hCAFEF00D);
    chk("oor_err_rf",   32'(err[0]), 32'd1);
    drive(1'b0, 1'b0, 32'd0, '0, 4'h0);
    chk("oor_err_clear", 32'(err[2]), 32'd0);
    drive(1'b0, 1'b1, 32'd0, '0, 4'h0);
    chk("oor_idx0_kept", rd[2], 32'hCAFEF00D);

    // Boundary index: 16 is out of range only for the 16-deep instances.
    drive(1'b1, 1'b1, 32'd16, 32'h0BADCAFE, 4'hF);
    chk("edge16_err_rf",  32'(err[0]), 32'd1);
    chk("edge16_err_big", 32'(err[2]), 32'd0);
    drive(1'b1, 1'b1, 32'd15, 32'h01020304, 4'hF);
    chk("edge15_err_rf", 32'(err[0]), 32'd0);
    chk("edge15_rd_wf",  rd[1], 32'h01020304);

    // re = 0 holds rdata while the address moves.
    drive(1'b1, 1'b0, 32'd2, 32'h12345678, 4'hF);
    drive(1'b0, 1'b1, 32'd2, '0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'(8 + i), 32'hFFFFFFFF, 4'hF);
      chk($sformatf("hold_%0d", i), rd[0], 32'h12345678);
    end

    // Mixed traffic checked by the model.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 20)), $urandom, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 32'(i), 32'h70000000 + 32'(i), 4'hF);
    drive(1'b0, 1'b0, '0, '0, 4'h0);

    // Reset mid-clear at index 9.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_clear_window("reclr");
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 32'(i), '0, 4'h0);
      chk($sformatf("reclr_rd%0d", i), rd[0], CLR);
    end
    drive(1'b0, 1'b0, '0, '0, 4'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_be.md
Name: dmem_be

Overview:
- Parametrised single-port synchronous data RAM for the core's load/store unit; next generation of the 8KB word-only data memory.
- Adds per-byte write enables, a selectable read-during-write mode, a read enable with output hold, out-of-range address detection, and an optional hardware clear sequencer that zeroes the array after reset.
- Sits between the LSU / store commit path and the FPGA BRAM.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 2048, number of words; must be a power of two, at least 2.
- ADDR_W, 32, width of the word-index address port.
- RDW_MODE, 0, read-during-write result: 0 = read-first (old data), 1 = write-first (merged new data).
- CLEAR_ON_RESET, 1, when 1, every word is written with CLR_VAL after reset.
- CLR_VAL, 0, DATA_W-bit fill value used by the clear sequencer.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  ADDR_W  word index (not a byte address).
- wdata  in  DATA_W  write data.
- we  in  1  write request.
- be  in  DATA_W/8  byte enables; bit i qualifies wdata[8i+7:8i].
- re  in  1  read request.
- rdata  out  DATA_W  registered read data.
- ready  out  1  high when the block accepts accesses.
- addr_err  out  1  registered; high for one cycle after an access to an out-of-range address.

Behaviour:
- IDX_W = clog2(DEPTH). The index is addr[IDX_W-1:0]. An access is out of range when any addr bit at IDX_W or above is nonzero.
- Reset values: rdata = 0, addr_err = 0. ready = 0 when CLEAR_ON_RESET = 1; ready = 1 from the first cycle after reset deasserts when CLEAR_ON_RESET = 0. Array contents are not reset.
- State machine, states CLEAR and RUN:
  - reset drives the FSM to CLEAR (CLEAR_ON_RESET = 1) or RUN (CLEAR_ON_RESET = 0), and sets the clear counter to 0.
  - In CLEAR, each cycle writes CLR_VAL to mem[counter] and increments the counter. After writing index DEPTH-1, the FSM goes to RUN.
  - The clear therefore takes exactly DEPTH cycles. ready rises in the cycle after the last clear write.
  - In CLEAR, we and re are ignored, rdata holds 0 and addr_err stays 0.
  - Asserting reset mid-clear restarts the clear from index 0.
- RUN, write:
  - Occurs when we = 1 and the address is in range.
  - For each i with be[i] = 1, byte i of mem[idx] takes wdata byte i. Bytes with be[i] = 0 are unchanged.
  - we = 1 with be = 0 is a no-op write.
- RUN, read:
  - Occurs when re = 1 and the address is in range.
  - rdata is updated on the next edge, giving 1-cycle latency.
  - When re = 0, rdata holds its previous value.
- Simultaneous we and re to the same word:
  - RDW_MODE 0: rdata returns the pre-write word.
  - RDW_MODE 1: rdata returns the word after the byte-enable merge.
- Out of range, with we or re set:
  - No array write occurs, rdata holds its value, and addr_err = 1 on the next cycle.
  - addr_err = 0 whenever the previous cycle had no out-of-range access.
- Index arithmetic is unsigned and truncated to IDX_W. The clear counter is IDX_W+1 bits so that termination is detected without wrap-around.

Decomposition:
- Shared constants header (the existing constants include) gains:
  - DMEM_RDW_READ_FIRST = 0 and DMEM_RDW_WRITE_FIRST = 1.
  - FSM state encodings DMEM_ST_CLEAR and DMEM_ST_RUN.
- One natural sub-module: dmem_be_bank, an 8-bit-wide single-port BRAM slice (DEPTH x 8, with its own we) instantiated DATA_W/8 times. This lets synthesis infer byte-write BRAM.
- The clear FSM, address checking, RDW muxing and output register live in dmem_be.

Test Plan:
- Clear sequence, DEPTH = 16, CLR_VAL = 32'hDEADBEEF: after reset, ready = 0 for exactly 16 cycles, then 1. Reading indices 0, 7 and 15 returns 32'hDEADBEEF. Accesses attempted during clear have no effect.
- Byte enables: write 32'h11223344 with be = 4'hF to index 5, then 32'hAABBCCDD with be = 4'b0101. Reading index 5 returns 32'h11BB33DD one cycle after re.
- Read-during-write: index 3 holds 32'h0, then we = re = 1 with wdata = 32'hFFFF0000 and be = 4'hC. RDW_MODE 0 returns 32'h00000000; RDW_MODE 1 returns 32'hFFFF0000.
- Out of range, DEPTH = 2048: we = 1 at addr = 32'h800 with wdata = 32'h5A5A5A5A. addr_err = 1 for one cycle, rdata is unchanged, and index 0 still holds its prior value.
- re = 0 hold: read index 2 (32'h12345678), then change addr with re = 0 for 3 cycles. rdata stays 32'h12345678.
- Reset mid-clear: assert reset at clear index 9 of 16. The clear restarts, ready rises 16 cycles after reset deasserts, and all indices read CLR_VAL.
